bnn_layer_engine: RTL and testbench

- Parametrised successor to the single-mode MNIST top. Computes one binarised fully-connected layer (XNOR-popcount-threshold) over LANES neurons in parallel, reading 1-bit activations and LANES-bit weight words from the external memory system.
- Arbitrates that memory between the off-chip load port and the compute FSM, and locks out the off-chip port while a layer is running.
- Provides a start/busy/done handshake and run-time layer configuration.

---
 rtl/bnn_layer_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_bnn_layer_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_engine.sv
// Binarised fully-connected layer engine.
// Evaluates LANES neurons per pass with XNOR-popcount-threshold, reading
// activations and weight words through a shared memory port that is
// otherwise owned by the off-chip loader.
//
// Handshake: start is a one-cycle request, accepted only while idle with
// load_mode=0 and no done pulse showing. busy is high from the cycle after
// acceptance until the final write has been issued. done is a one-cycle pulse
// with busy already low, and a start seen in that same cycle is ignored. Any
// other start is dropped silently.
module bnn_layer_engine #(
  parameter int LANES       = 4,
  parameter int MAX_IN      = 1024,
  parameter int MAX_OUT     = 256,
  parameter int W_ADDR_LEN  = 20,
  parameter int X_ADDR_LEN  = 10,
  parameter int SEL_LEN     = 2,
  parameter int COMPUTE_SEL = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_mode,
  input  logic                           start,
  input  logic [$clog2(MAX_IN+1)-1:0]    cfg_n_in,
  input  logic [$clog2(MAX_OUT+1)-1:0]   cfg_n_out,
  input  logic [$clog2(MAX_IN+1)-1:0]    cfg_thresh,
  input  logic [X_ADDR_LEN-1:0]          cfg_x_in_base,
  input  logic [X_ADDR_LEN-1:0]          cfg_x_out_base,
  input  logic                           oc_w_we,
  input  logic                           oc_x_we,
  input  logic [W_ADDR_LEN-1:0]          oc_w_addr,
  input  logic [X_ADDR_LEN-1:0]          oc_x_addr,
  input  logic [SEL_LEN-1:0]             oc_w_sel,
  input  logic [SEL_LEN-1:0]             oc_x_sel,
  input  logic                           oc_wdata,
  output logic                           mem_w_we,
  output logic                           mem_x_we,
  output logic [W_ADDR_LEN-1:0]          mem_w_addr,
  output logic [X_ADDR_LEN-1:0]          mem_x_addr,
  output logic [SEL_LEN-1:0]             mem_w_sel,
  output logic [SEL_LEN-1:0]             mem_x_sel,
  output logic                           mem_wdata,
  input  logic [LANES-1:0]               mem_w_rdata,
  input  logic                           mem_x_rdata,
  output logic                           busy,
  output logic                           done,
  output logic                           oc_reject,
  output logic [1:0]                     dbg_state
);

  localparam int NI_W = $clog2(MAX_IN + 1);
  localparam int NO_W = $clog2(MAX_OUT + 1);
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  // Neuron index width with headroom for base + LANES past n_out.
  localparam int K_W  = NO_W + LW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, FIN} state_t;

  state_t                  state_q, state_d;
  logic [NI_W-1:0]         n_in_q, n_in_d;
  logic [NO_W-1:0]         n_out_q, n_out_d;
  logic [NI_W-1:0]         thresh_q, thresh_d;
  logic [X_ADDR_LEN-1:0]   x_in_base_q, x_in_base_d;
  logic [X_ADDR_LEN-1:0]   x_out_base_q, x_out_base_d;
  logic [NI_W-1:0]         i_q, i_d;
  logic [LW-1:0]           lane_q, lane_d;
  // First neuron of the current group and first weight address of the
  // group; both advance by a constant step so no multiplier is needed.
  logic [K_W-1:0]          k_base_q, k_base_d;
  logic [W_ADDR_LEN-1:0]   w_base_q, w_base_d;
  logic [NI_W-1:0]         acc_q [LANES];
  logic [NI_W-1:0]         acc_d [LANES];
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [NI_W-1:0]         n_in_sat;
  logic [NO_W-1:0]         n_out_sat;
  logic                    start_ok;
  logic [K_W-1:0]          k_cur;
  logic                    lane_live;
  logic                    last_in;
  logic                    last_lane;
  logic                    more_groups;
  logic [LANES-1:0]        match;

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign oc_reject = busy_q & load_mode & (oc_w_we | oc_x_we);

  // Shared decode terms for the sequencer and the memory mux.
  always_comb begin
    n_in_sat    = (cfg_n_in > NI_W'(MAX_IN)) ? NI_W'(MAX_IN) : cfg_n_in;
    n_out_sat   = (cfg_n_out > NO_W'(MAX_OUT)) ? NO_W'(MAX_OUT) : cfg_n_out;
    // done_q marks the closing cycle of a layer, which must not restart it.
    start_ok    = (state_q == IDLE) && start && !load_mode && !done_q;
    k_cur       = k_base_q + K_W'(lane_q);
    lane_live   = k_cur < K_W'(n_out_q);
    last_in     = (i_q == n_in_q - NI_W'(1));
    last_lane   = (lane_q == LW'(LANES - 1));
    more_groups = (k_base_q + K_W'(LANES)) < K_W'(n_out_q);
    match       = ~({LANES{mem_x_rdata}} ^ mem_w_rdata);
  end

  // Memory port ownership: off-chip when idle in load mode, engine otherwise.
  always_comb begin
    mem_w_we   = 1'b0;
    mem_x_we   = 1'b0;
    mem_w_addr = '0;
    mem_x_addr = '0;
    mem_w_sel  = '0;
    mem_x_sel  = '0;
    mem_wdata  = 1'b0;
    if (state_q == IDLE) begin
      if (load_mode) begin
        mem_w_we   = oc_w_we & rst;
        mem_x_we   = oc_x_we & rst;
        mem_w_addr = oc_w_addr;
        mem_x_addr = oc_x_addr;
        mem_w_sel  = oc_w_sel;
        mem_x_sel  = oc_x_sel;
        mem_wdata  = oc_wdata;
      end
    end else begin
      mem_w_sel  = SEL_LEN'(COMPUTE_SEL);
      mem_x_sel  = SEL_LEN'(COMPUTE_SEL);
      mem_w_addr = w_base_q + W_ADDR_LEN'(i_q);
      if (state_q == WRITE) begin
        mem_x_addr = x_out_base_q + X_ADDR_LEN'(k_cur);
        mem_x_we   = lane_live;
        mem_wdata  = lane_live && (acc_q[lane_q] >= thresh_q);
      end else begin
        mem_x_addr = x_in_base_q + X_ADDR_LEN'(i_q);
      end
    end
  end

  // Layer sequencer: next-state, counters and accumulators.
  always_comb begin
    state_d      = state_q;
    n_in_d       = n_in_q;
    n_out_d      = n_out_q;
    thresh_d     = thresh_q;
    x_in_base_d  = x_in_base_q;
    x_out_base_d = x_out_base_q;
    i_d          = i_q;
    lane_d       = lane_q;
    k_base_d     = k_base_q;
    w_base_d     = w_base_q;
    acc_d        = acc_q;
    done_d       = (state_q == FIN);
    busy_d       = (state_q == ACCUM) || (state_q == WRITE);
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          n_in_d       = n_in_sat;
          n_out_d      = n_out_sat;
          thresh_d     = cfg_thresh;
          x_in_base_d  = cfg_x_in_base;
          x_out_base_d = cfg_x_out_base;
          i_d          = '0;
          lane_d       = '0;
          k_base_d     = '0;
          w_base_d     = '0;
          for (int l = 0; l < LANES; l++) acc_d[l] = '0;
          state_d = ((n_in_sat == '0) || (n_out_sat == '0)) ? FIN : ACCUM;
        end
      end
      ACCUM: begin
        for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l] + NI_W'(match[l]);
        if (last_in) begin
          i_d     = '0;
          lane_d  = '0;
          state_d = WRITE;
        end else begin
          i_d = i_q + NI_W'(1);
        end
      end
      WRITE: begin
        if (last_lane) begin
          lane_d = '0;
          for (int l = 0; l < LANES; l++) acc_d[l] = '0;
          if (more_groups) begin
            k_base_d = k_base_q + K_W'(LANES);
            w_base_d = w_base_q + W_ADDR_LEN'(n_in_q);
            state_d  = ACCUM;
          end else begin
            state_d = FIN;
          end
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      n_in_q       <= '0;
      n_out_q      <= '0;
      thresh_q     <= '0;
      x_in_base_q  <= '0;
      x_out_base_q <= '0;
      i_q          <= '0;
      lane_q       <= '0;
      k_base_q     <= '0;
      w_base_q     <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_in_q       <= n_in_d;
      n_out_q      <= n_out_d;
      thresh_q     <= thresh_d;
      x_in_base_q  <= x_in_base_d;
      x_out_base_q <= x_out_base_d;
      i_q          <= i_d;
      lane_q       <= lane_d;
      k_base_q     <= k_base_d;
      w_base_q     <= w_base_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Testbench for bnn_layer_engine: bench-side memory model, per-neuron
// popcount reference, write scoreboard and latency checks.
module tb_bnn_layer_engine;

  localparam int LANES      = 4;
  localparam int MAX_IN     = 1024;
  localparam int MAX_OUT    = 256;
  localparam int W_ADDR_LEN = 20;
  localparam int X_ADDR_LEN = 10;
  localparam int SEL_LEN    = 2;
  localparam int NI_W       = $clog2(MAX_IN + 1);
  localparam int NO_W       = $clog2(MAX_OUT + 1);
  localparam int XDEPTH     = 1 << X_ADDR_LEN;
  localparam int WDEPTH     = 1 << W_ADDR_LEN;
  localparam int EW         = X_ADDR_LEN + 1;

  logic                  clk;
  logic                  rst;
  logic                  load_mode;
  logic                  start;
  logic [NI_W-1:0]       cfg_n_in;
  logic [NO_W-1:0]       cfg_n_out;
  logic [NI_W-1:0]       cfg_thresh;
  logic [X_ADDR_LEN-1:0] cfg_x_in_base;
  logic [X_ADDR_LEN-1:0] cfg_x_out_base;
  logic                  oc_w_we;
  logic                  oc_x_we;
  logic [W_ADDR_LEN-1:0] oc_w_addr;
  logic [X_ADDR_LEN-1:0] oc_x_addr;
  logic [SEL_LEN-1:0]    oc_w_sel;
  logic [SEL_LEN-1:0]    oc_x_sel;
  logic                  oc_wdata;
  logic                  mem_w_we;
  logic                  mem_x_we;
  logic [W_ADDR_LEN-1:0] mem_w_addr;
  logic [X_ADDR_LEN-1:0] mem_x_addr;
  logic [SEL_LEN-1:0]    mem_w_sel;
  logic [SEL_LEN-1:0]    mem_x_sel;
  logic                  mem_wdata;
  logic [LANES-1:0]      mem_w_rdata;
  logic                  mem_x_rdata;
  logic                  busy;
  logic                  done;
  logic                  oc_reject;
  logic [1:0]            dbg_state;

  // Memory system model: banked activations, single weight bank.
  logic                  x_mem [4][XDEPTH];
  logic [LANES-1:0]      w_mem [WDEPTH];

  logic [EW-1:0]         exp_q[$];
  logic [EW-1:0]         obs_q[$];
  int                    n_checks;
  int                    n_fail;
  int                    w_we_seen;
  int                    sel_bad;
  bit                    capture_on;

  bnn_layer_engine dut (
    .clk            (clk),
    .rst            (rst),
    .load_mode      (load_mode),
    .start          (start),
    .cfg_n_in       (cfg_n_in),
    .cfg_n_out      (cfg_n_out),
    .cfg_thresh     (cfg_thresh),
    .cfg_x_in_base  (cfg_x_in_base),
    .cfg_x_out_base (cfg_x_out_base),
    .oc_w_we        (oc_w_we),
    .oc_x_we        (oc_x_we),
    .oc_w_addr      (oc_w_addr),
    .oc_x_addr      (oc_x_addr),
    .oc_w_sel       (oc_w_sel),
    .oc_x_sel       (oc_x_sel),
    .oc_wdata       (oc_wdata),
    .mem_w_we       (mem_w_we),
    .mem_x_we       (mem_x_we),
    .mem_w_addr     (mem_w_addr),
    .mem_x_addr     (mem_x_addr),
    .mem_w_sel      (mem_w_sel),
    .mem_x_sel      (mem_x_sel),
    .mem_wdata      (mem_wdata),
    .mem_w_rdata    (mem_w_rdata),
    .mem_x_rdata    (mem_x_rdata),
    .busy           (busy),
    .done           (done),
    .oc_reject      (oc_reject),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Combinational reads, clocked writes, write logging.
  assign mem_x_rdata = x_mem[mem_x_sel][mem_x_addr];
  assign mem_w_rdata = w_mem[mem_w_addr];

  always @(posedge clk) begin
    if (mem_x_we) begin
      x_mem[mem_x_sel][mem_x_addr] <= mem_wdata;
      if (capture_on) begin
        obs_q.push_back({mem_x_addr, mem_wdata});
        if (mem_x_sel != '0) sel_bad++;
      end
    end
    if (mem_w_we && capture_on) w_we_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: each neuron k counts agreements between its inputs and
  // bit k%LANES of its group's weight words, then thresholds.
  task automatic build_expected(input int n_in_cfg, input int n_out_cfg, input int thr,
                                input int xin, input int xout, output int lat);
    int ni, no, pop, groups;
    logic [X_ADDR_LEN-1:0] a;
    logic o;
    ni = (n_in_cfg > MAX_IN) ? MAX_IN : n_in_cfg;
    no = (n_out_cfg > MAX_OUT) ? MAX_OUT : n_out_cfg;
    exp_q.delete();
    if (ni == 0 || no == 0) begin
      lat = 2;
      return;
    end
    groups = (no + LANES - 1) / LANES;
    lat = groups * (ni + LANES) + 2;
    for (int k = 0; k < no; k++) begin
      pop = 0;
      for (int i = 0; i < ni; i++) begin
        if (x_mem[0][(xin + i) % XDEPTH] == w_mem[((k / LANES) * ni + i) % WDEPTH][k % LANES])
          pop++;
      end
      o = (pop >= thr);
      a = X_ADDR_LEN'((xout + k) % XDEPTH);
      exp_q.push_back({a, o});
    end
  endtask

  task automatic rand_fill(input int n_w);
    for (int a = 0; a < XDEPTH; a++) x_mem[0][a] = 1'($urandom_range(0, 1));
    for (int a = 0; a < n_w; a++) w_mem[a] = LANES'($urandom_range(0, (1 << LANES) - 1));
  endtask

  task automatic oc_write_x(input int addr, input logic data);
    @(negedge clk);
    load_mode = 1'b1;
    oc_x_we   = 1'b1;
    oc_x_sel  = '0;
    oc_x_addr = X_ADDR_LEN'(addr);
    oc_wdata  = data;
  endtask

  // Driver: launch a layer, track latency, optional lockout / reset hooks,
  // then score the captured writes against the reference.
  task automatic run_layer(input int n_in_cfg, input int n_out_cfg, input int thr,
                           input int xin, input int xout, input string tag,
                           input int lock_at, input int abort_at);
    int lat, cycles, nw;
    bit got_done, aborted, done_busy;
    logic [EW-1:0] o, e;
    logic [X_ADDR_LEN-1:0] lock_addr;
    build_expected(n_in_cfg, n_out_cfg, thr, xin, xout, lat);
    obs_q.delete();
    w_we_seen = 0;
    sel_bad   = 0;
    lock_addr = X_ADDR_LEN'(xin + 2);
    @(negedge clk);
    cfg_n_in       = NI_W'(n_in_cfg);
    cfg_n_out      = NO_W'(n_out_cfg);
    cfg_thresh     = NI_W'(thr);
    cfg_x_in_base  = X_ADDR_LEN'(xin);
    cfg_x_out_base = X_ADDR_LEN'(xout);
    start          = 1'b1;
    capture_on     = 1'b1;
    cycles = 0; got_done = 0; aborted = 0; done_busy = 0;
    while (cycles < lat + 40 && !got_done && !aborted) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = 1'b0;
      if (cycles == 2 && lat > 2) check({tag, "_busy"}, busy, 1);
      if (lock_at > 0 && cycles == lock_at) begin
        load_mode = 1'b1;
        oc_x_we   = 1'b1;
        oc_x_sel  = '0;
        oc_x_addr = lock_addr;
        oc_wdata  = ~x_mem[0][lock_addr];
        #1;
        check({tag, "_reject"}, oc_reject, 1);
        check({tag, "_lock_we"}, mem_x_we, 0);
      end
      if (lock_at > 0 && cycles == lock_at + 3) begin
        load_mode = 1'b0;
        oc_x_we   = 1'b0;
      end
      if (cycles == abort_at) begin
        check({tag, "_pre_abort_we"}, mem_x_we, 1);
        #2 rst = 1'b0;
        #1;
        check({tag, "_abort_busy"}, busy, 0);
        check({tag, "_abort_done"}, done, 0);
        check({tag, "_abort_we"}, mem_x_we, 0);
        aborted = 1;
      end
      if (done) begin
        got_done  = 1;
        done_busy = busy;
      end
    end
    if (aborted) begin
      nw = obs_q.size();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check({tag, "_no_write_after_abort"}, obs_q.size(), nw);
      capture_on = 1'b0;
      return;
    end
    check({tag, "_latency"}, cycles, lat);
    check({tag, "_busy_at_done"}, done_busy, 0);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    capture_on = 1'b0;
    check({tag, "_n_writes"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, o, e);
    end
    check({tag, "_w_we"}, w_we_seen, 0);
    check({tag, "_sel"}, sel_bad, 0);
  endtask

  logic [7:0] pat;
  int         mism [LANES];
  logic       saved;
  int         ni, no, th, xi;

  // Main sequence
  initial begin
    n_checks = 0; n_fail = 0; capture_on = 0; w_we_seen = 0; sel_bad = 0;
    rst = 1'b0; load_mode = 1'b1; start = 1'b0;
    cfg_n_in = '0; cfg_n_out = '0; cfg_thresh = '0;
    cfg_x_in_base = '0; cfg_x_out_base = '0;
    oc_w_we = 1'b0; oc_x_we = 1'b1; oc_w_addr = '0; oc_x_addr = 10'd7;
    oc_w_sel = '0; oc_x_sel = '0; oc_wdata = 1'b1;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_reject", oc_reject, 0);
    check("reset_x_we", mem_x_we, 0);
    @(negedge clk);
    oc_x_we = 1'b0;
    rst = 1'b1;

    // Load x[0..7] = 1,0,1,1,0,0,1,0 through the off-chip port.
    pat = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      oc_write_x(i, pat[7-i]);
      if (i == 3) begin
        #1;
        check("pass_x_we", mem_x_we, 1);
        check("pass_x_addr", mem_x_addr, 3);
      end
    end
    @(negedge clk);
    oc_x_we = 1'b0;
    for (int i = 0; i < 8; i++) check("load_x", x_mem[0][i], pat[7-i]);

    // Lane l disagrees on the first mism[l] inputs: popcounts 8,4,5,0.
    mism[0] = 0; mism[1] = 4; mism[2] = 3; mism[3] = 8;
    for (int i = 0; i < 8; i++)
      for (int l = 0; l < LANES; l++)
        w_mem[i][l] = pat[7-i] ^ (i < mism[l]);

    // Idle with load_mode=0: port parked.
    load_mode = 1'b0;
    oc_x_we   = 1'b1;
    oc_x_addr = 10'd5;
    #1;
    check("park_x_we", mem_x_we, 0);
    check("park_x_addr", mem_x_addr, 0);
    @(negedge clk);
    oc_x_we = 1'b0;

    run_layer(8, 4, 5, 0, 100, "load", -1, -1);
    check("load_out0", x_mem[0][100], 1);
    check("load_out1", x_mem[0][101], 0);
    check("load_out2", x_mem[0][102], 1);
    check("load_out3", x_mem[0][103], 0);

    // Partial final group, threshold 0.
    rand_fill(8);
    run_layer(3, 6, 0, 200, 300, "partial", -1, -1);

    // Off-chip write attempted mid-ACCUM.
    rand_fill(12);
    saved = x_mem[0][22];
    run_layer(10, 4, 6, 20, 500, "lock", 3, -1);
    check("lock_x_intact", x_mem[0][22], saved);

    // Start while in load mode is ignored.
    @(negedge clk);
    load_mode = 1'b1;
    start     = 1'b1;
    cfg_n_in  = NI_W'(4);
    cfg_n_out = NO_W'(4);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("lm_start_busy", busy, 0);
    check("lm_start_done", done, 0);
    load_mode = 1'b0;

    // Zero-size layers.
    run_layer(0, 5, 0, 0, 400, "zero_in", -1, -1);
    run_layer(5, 0, 0, 0, 400, "zero_out", -1, -1);

    // Saturated input count with all inputs agreeing.
    for (int a = 0; a < XDEPTH; a++) x_mem[0][a] = 1'b1;
    for (int a = 0; a < MAX_IN; a++) w_mem[a] = '1;
    run_layer(MAX_IN + 5, 4, MAX_IN, 0, 0, "sat_hi", -1, -1);
    run_layer(MAX_IN + 5, 4, MAX_IN + 1, 0, 0, "sat_lo", -1, -1);

    // Randomized layers, including address wrap of the input window.
    for (int t = 0; t < 6; t++) begin
      ni = $urandom_range(1, 40);
      no = $urandom_range(1, 20);
      th = $urandom_range(0, ni + 1);
      xi = (t == 0) ? 1010 : $urandom_range(0, XDEPTH - 1);
      rand_fill(((no + LANES - 1) / LANES) * ni);
      run_layer(ni, no, th, xi, (xi + ni + 50) % XDEPTH, "rand", -1, -1);
    end

    // Asynchronous reset during WRITE, then a clean rerun.
    rand_fill(8);
    run_layer(4, 8, 2, 600, 700, "abort", -1, 6);
    run_layer(4, 8, 2, 600, 700, "rerun", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
